mkio_rx_writer: RTL and testbench
=================================

MKIO_RX_WRITER -- requirements
Module: mkio_rx_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, MKIO word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, subaddress memory address width (32 words).
REQ-003 SHALL have parameter GAP_CYCLES, default 400, maximum idle clocks between data words of one message.
REQ-004 SHALL have port clock, input, 1, single clock for all logic.
REQ-005 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-006 SHALL have port rt_addr, input, 5, own terminal address.
REQ-007 SHALL have port word_valid, input, 1, one-cycle strobe: decoded word present.
REQ-008 SHALL have port word_data, input, DATA_WIDTH, decoded word.
REQ-009 SHALL have port word_is_cmd, input, 1, word carried command/status sync.
REQ-010 SHALL have port word_par_err, input, 1, word failed parity/Manchester check.
REQ-011 SHALL have port mem_data, output, DATA_WIDTH, write data to subaddress memory.
REQ-012 SHALL have port mem_addr, output, ADDR_WIDTH, write address.
REQ-013 SHALL have port mem_we, output, 1, write enable.
REQ-014 SHALL have port sub_addr, output, 5, subaddress of the current/last accepted command.
REQ-015 SHALL have port rx_busy, output, 1, high while in RECV.
REQ-016 SHALL have port msg_done, output, 1, one-cycle pulse: message received completely.
REQ-017 SHALL have port msg_err, output, 1, one-cycle pulse: message aborted.
REQ-018 SHALL have port err_code, output, 2, abort cause (1 parity, 2 unexpected command, 3 gap timeout); held until next pulse.

Function
REQ-019 SHALL implement states IDLE and RECV.
REQ-020 In IDLE, a word with word_valid=1, word_is_cmd=1 and word_par_err=0 SHALL be accepted when bits[15:11] equal rt_addr or 31, bit[10]=0 (receive), and bits[9:5] are neither 0 nor 31 (mode codes ignored).
REQ-021 On acceptance: sub_addr<=bits[9:5]; word_cnt target<=bits[4:0], with 0 meaning 32; index<=0; state<=RECV.
REQ-022 Non-accepted words in IDLE SHALL be ignored, with no output change.
REQ-023 In RECV, a valid data word (word_is_cmd=0, word_par_err=0) SHALL produce mem_we=1, mem_addr=index[4:0] and mem_data=word_data on the next cycle (1-cycle latency), then index+1.
REQ-024 Index and target SHALL be 6 bits; when the written word is number target, msg_done SHALL pulse in the same cycle as that mem_we, and state SHALL return to IDLE.
REQ-025 In RECV, word_valid with word_par_err=1 SHALL abort: no write, msg_err pulse next cycle, err_code=1, state IDLE.
REQ-026 In RECV, word_valid with word_is_cmd=1 and no parity error SHALL abort with err_code=2, and in the same cycle that word SHALL be evaluated under REQ-020 (it may start a new message).
REQ-027 In RECV, GAP_CYCLES consecutive clocks without word_valid SHALL abort with err_code=3.
REQ-028 The gap counter SHALL clear on every word_valid and on entry to RECV.
REQ-029 Words already written before an abort SHALL not be rolled back; msg_err marks the buffer invalid.
REQ-030 mem_we, msg_done and msg_err SHALL never be high for more than one cycle per event, and msg_done and msg_err SHALL never be high together.

Reset
REQ-031 While reset=1: state=IDLE; mem_we=0, msg_done=0, msg_err=0, rx_busy=0; mem_addr=0, mem_data=0, sub_addr=0, err_code=0; index and gap counter cleared.
REQ-032 Reset asserted mid-message SHALL discard the message without any msg_done or msg_err pulse.

Structure
REQ-033 Package mkio_pkg SHALL hold the state enum, the err_code enum, the command-word field positions, and BROADCAST_ADDR=31.
REQ-034 The gap counter SHALL be sub-module mkio_gap_timer (inputs clear and enable, output expired).
REQ-035 Outputs SHALL be registered and drive the write port of the subaddress memory directly, with the same clock on that port.

Verification
REQ-036 rt_addr=5, command 0x2843 (RT5, receive, SA2, WC3) then data 0x1111, 0x2222, 0x3333 -> writes at addresses 0,1,2; msg_done with the third write; sub_addr=2.
REQ-037 Command 0x2840 (WC0) then 32 data words -> addresses 0..31 written; msg_done on write 32, with no wrap or extra write.
REQ-038 Command 0x2843, one data word, then a word with word_par_err=1 -> one write only; msg_err pulse with err_code=1; state IDLE.
REQ-039 Command 0x2843, one data word, then a new command 0x2822 -> err_code=2, and the new message is accepted with sub_addr=1 and target 2.
REQ-040 Command 0x2843 followed by GAP_CYCLES idle clocks -> msg_err with err_code=3 exactly GAP_CYCLES cycles after the last word; commands 0xF843 (broadcast) are accepted, while 0x3043 (other RT), 0x2C43 (transmit) and 0x2803 (SA0) are ignored.

Source files
------------

// File: rtl/mkio_pkg.sv
// rtl/mkio_pkg.sv - shared types and command-word layout for the MKIO receive writer
package mkio_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_PARITY = 2'd1,
    ERR_CMD    = 2'd2,
    ERR_GAP    = 2'd3
  } err_code_e;

  // Command word layout: RT address, T/R bit, subaddress, word count
  localparam int CMD_RT_HI  = 15;
  localparam int CMD_RT_LO  = 11;
  localparam int CMD_TR_BIT = 10;
  localparam int CMD_SA_HI  = 9;
  localparam int CMD_SA_LO  = 5;
  localparam int CMD_WC_HI  = 4;
  localparam int CMD_WC_LO  = 0;

  localparam logic [4:0] BROADCAST_ADDR = 5'd31;

  // Subaddresses 0 and 31 carry mode codes, which this block does not handle
  localparam logic [4:0] MODE_SA_LO = 5'd0;
  localparam logic [4:0] MODE_SA_HI = 5'd31;

  // A word count field of zero stands for a full 32-word message
  function automatic logic [5:0] wc_to_target(input logic [4:0] wc);
    return (wc == 5'd0) ? 6'd32 : {1'b0, wc};
  endfunction

endpackage

// File: rtl/mkio_gap_timer.sv
// rtl/mkio_gap_timer.sv - counts idle clocks between data words of a message
module mkio_gap_timer #(
  parameter int GAP_CYCLES = 400
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(GAP_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  // expired marks the clock that completes GAP_CYCLES consecutive idle clocks
  assign expired = enable && !clear && (r_cnt == CW'(GAP_CYCLES - 1));

  // Idle-clock counter; any clear restarts the window
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (enable && !expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mkio_rx_writer.sv
// rtl/mkio_rx_writer.sv - accepts receive commands and writes following data words to subaddress memory
module mkio_rx_writer
  import mkio_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int GAP_CYCLES = 400
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4:0]            rt_addr,
  input  logic                  word_valid,
  input  logic [DATA_WIDTH-1:0] word_data,
  input  logic                  word_is_cmd,
  input  logic                  word_par_err,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [4:0]            sub_addr,
  output logic                  rx_busy,
  output logic                  msg_done,
  output logic                  msg_err,
  output logic [1:0]            err_code
);

  state_e                r_state;
  err_code_e             r_err_code;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_we;
  logic [4:0]            r_sub_addr;
  logic                  r_rx_busy;
  logic                  r_msg_done;
  logic                  r_msg_err;
  logic [5:0]            r_index;
  logic [5:0]            r_target;

  logic [4:0] w_rt;
  logic       w_tr;
  logic [4:0] w_sa;
  logic [4:0] w_wc;
  logic       w_cmd_ok;
  logic [5:0] w_index_next;
  logic       w_gap_clear;
  logic       w_gap_enable;
  logic       w_gap_expired;

  assign w_rt = word_data[CMD_RT_HI:CMD_RT_LO];
  assign w_tr = word_data[CMD_TR_BIT];
  assign w_sa = word_data[CMD_SA_HI:CMD_SA_LO];
  assign w_wc = word_data[CMD_WC_HI:CMD_WC_LO];

  // A clean receive command for this terminal (or broadcast) to a data subaddress
  assign w_cmd_ok = word_valid && word_is_cmd && !word_par_err
                 && ((w_rt == rt_addr) || (w_rt == BROADCAST_ADDR))
                 && !w_tr
                 && (w_sa != MODE_SA_LO) && (w_sa != MODE_SA_HI);

  assign w_index_next = r_index + 6'd1;

  // The gap window only runs while receiving and restarts on every word
  assign w_gap_enable = (r_state == ST_RECV);
  assign w_gap_clear  = word_valid || (r_state != ST_RECV);

  mkio_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (w_gap_clear),
    .enable (w_gap_enable),
    .expired(w_gap_expired)
  );

  assign mem_data = r_mem_data;
  assign mem_addr = r_mem_addr;
  assign mem_we   = r_mem_we;
  assign sub_addr = r_sub_addr;
  assign rx_busy  = r_rx_busy;
  assign msg_done = r_msg_done;
  assign msg_err  = r_msg_err;
  assign err_code = r_err_code;

  // Receive FSM with registered memory write port and status pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_err_code <= ERR_NONE;
      r_mem_data <= '0;
      r_mem_addr <= '0;
      r_mem_we   <= 1'b0;
      r_sub_addr <= '0;
      r_rx_busy  <= 1'b0;
      r_msg_done <= 1'b0;
      r_msg_err  <= 1'b0;
      r_index    <= '0;
      r_target   <= '0;
    end else begin
      r_mem_we   <= 1'b0;
      r_msg_done <= 1'b0;
      r_msg_err  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_cmd_ok) begin
            r_sub_addr <= w_sa;
            r_target   <= wc_to_target(w_wc);
            r_index    <= '0;
            r_state    <= ST_RECV;
            r_rx_busy  <= 1'b1;
          end
        end
        ST_RECV: begin
          if (word_valid) begin
            if (word_par_err) begin
              r_msg_err  <= 1'b1;
              r_err_code <= ERR_PARITY;
              r_state    <= ST_IDLE;
              r_rx_busy  <= 1'b0;
            end else if (word_is_cmd) begin
              // The interrupting command aborts this message and may open the next one
              r_msg_err  <= 1'b1;
              r_err_code <= ERR_CMD;
              if (w_cmd_ok) begin
                r_sub_addr <= w_sa;
                r_target   <= wc_to_target(w_wc);
                r_index    <= '0;
                r_state    <= ST_RECV;
                r_rx_busy  <= 1'b1;
              end else begin
                r_state    <= ST_IDLE;
                r_rx_busy  <= 1'b0;
              end
            end else begin
              r_mem_we   <= 1'b1;
              r_mem_addr <= ADDR_WIDTH'(r_index[4:0]);
              r_mem_data <= word_data;
              r_index    <= w_index_next;
              if (w_index_next == r_target) begin
                r_msg_done <= 1'b1;
                r_state    <= ST_IDLE;
                r_rx_busy  <= 1'b0;
              end
            end
          end else if (w_gap_expired) begin
            r_msg_err  <= 1'b1;
            r_err_code <= ERR_GAP;
            r_state    <= ST_IDLE;
            r_rx_busy  <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mkio_rx_writer.sv
// tb/tb_mkio_rx_writer.sv - randomized scoreboard bench for mkio_rx_writer
module tb_mkio_rx_writer;

  localparam int GAP    = 400;
  localparam logic [4:0] MY_RT = 5'd5;

  logic        clock;
  logic        reset;
  logic [4:0]  rt_addr;
  logic        word_valid;
  logic [15:0] word_data;
  logic        word_is_cmd;
  logic        word_par_err;
  logic [15:0] mem_data;
  logic [4:0]  mem_addr;
  logic        mem_we;
  logic [4:0]  sub_addr;
  logic        rx_busy;
  logic        msg_done;
  logic        msg_err;
  logic [1:0]  err_code;

  mkio_rx_writer #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(5),
    .GAP_CYCLES(GAP)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rt_addr     (rt_addr),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .word_is_cmd (word_is_cmd),
    .word_par_err(word_par_err),
    .mem_data    (mem_data),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .sub_addr    (sub_addr),
    .rx_busy     (rx_busy),
    .msg_done    (msg_done),
    .msg_err     (msg_err),
    .err_code    (err_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          stamp;
    bit          is_err;
    int          addr;
    logic [15:0] data;
    bit          done;
    int          code;
    int          sa;
    bit          busy;
  } ev_t;

  ev_t exp_q[$];

  // Reference model state: what a receiver should remember between words
  bit m_busy   = 0;
  int m_sa     = 0;
  int m_target = 0;
  int m_idx    = 0;
  int m_idle   = 0;
  int m_code   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit accepts(input bit v, input logic [15:0] d, input bit c, input bit p);
    logic [4:0] rt;
    logic [4:0] sa;
    rt = d[15:11];
    sa = d[9:5];
    return v && c && !p && (rt == MY_RT || rt == 5'd31) && !d[10] && sa != 5'd0 && sa != 5'd31;
  endfunction

  task automatic m_start(input logic [15:0] d);
    m_busy   = 1;
    m_sa     = int'(d[9:5]);
    m_target = (d[4:0] == 5'd0) ? 32 : int'(d[4:0]);
    m_idx    = 0;
    m_idle   = 0;
  endtask

  task automatic push_err(input int st);
    ev_t e;
    e.stamp = st; e.is_err = 1; e.addr = 0; e.data = '0; e.done = 0;
    e.code = m_code; e.sa = m_sa; e.busy = m_busy;
    exp_q.push_back(e);
  endtask

  // One clock of the message protocol, stamped with the cycle its response appears
  task automatic model(input bit v, input logic [15:0] d, input bit c, input bit p, input int st);
    ev_t e;
    if (!m_busy) begin
      if (accepts(v, d, c, p)) m_start(d);
    end else if (!v) begin
      m_idle++;
      if (m_idle == GAP) begin
        m_busy = 0; m_code = 3; push_err(st);
      end
    end else begin
      m_idle = 0;
      if (p) begin
        m_busy = 0; m_code = 1; push_err(st);
      end else if (c) begin
        m_busy = 0; m_code = 2;
        if (accepts(v, d, c, p)) m_start(d);
        push_err(st);
      end else begin
        e.stamp = st; e.is_err = 0; e.addr = m_idx; e.data = d;
        e.done = (m_idx + 1 == m_target);
        m_idx++;
        if (e.done) m_busy = 0;
        e.code = m_code; e.sa = m_sa; e.busy = m_busy;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic step(input bit v, input logic [15:0] d, input bit c, input bit p);
    @(posedge clock); #1;
    reset = 0; word_valid = v; word_data = d; word_is_cmd = c; word_par_err = p;
    model(v, d, c, p, cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'h0000, 0, 0);
  endtask

  task automatic data(input logic [15:0] d);
    step(1, d, 0, 0);
  endtask

  task automatic cmd(input logic [15:0] d);
    step(1, d, 1, 0);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1; word_valid = 0; word_is_cmd = 0; word_par_err = 0;
    m_busy = 0; m_idle = 0; m_sa = 0; m_code = 0; m_idx = 0;
  endtask

  // Monitor: every write or abort pulse must match the oldest expected event
  always @(negedge clock) begin
    ev_t e;
    while (exp_q.size() != 0 && exp_q[0].stamp < cyc) begin
      e = exp_q.pop_front();
      chk("missing_event_stamp", 32'(cyc), 32'(e.stamp));
    end
    if (mem_we === 1'b1 || msg_err === 1'b1 || msg_done === 1'b1) begin
      if (exp_q.size() == 0 || exp_q[0].stamp != cyc) begin
        chk("unexpected_event_we_err_done", {29'd0, mem_we, msg_err, msg_done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("msg_err", 32'(msg_err), 32'(e.is_err));
        chk("mem_we", 32'(mem_we), 32'(!e.is_err));
        chk("msg_done", 32'(msg_done), 32'(e.done));
        if (!e.is_err) begin
          chk("mem_addr", 32'(mem_addr), 32'(e.addr));
          chk("mem_data", 32'(mem_data), 32'(e.data));
        end
        chk("err_code", 32'(err_code), 32'(e.code));
        chk("sub_addr", 32'(sub_addr), 32'(e.sa));
        chk("rx_busy", 32'(rx_busy), 32'(e.busy));
      end
    end
  end

  initial begin
    logic [4:0]  rt, sa, wc;
    logic        tr;
    logic [15:0] cw;
    int          n, r, gap_at;
    bit          long_gap;

    rt_addr = MY_RT;
    reset = 1; word_valid = 0; word_data = '0; word_is_cmd = 0; word_par_err = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_mem_we", 32'(mem_we), 0);
    chk("reset_msg_done", 32'(msg_done), 0);
    chk("reset_msg_err", 32'(msg_err), 0);
    chk("reset_rx_busy", 32'(rx_busy), 0);
    chk("reset_mem_addr", 32'(mem_addr), 0);
    chk("reset_mem_data", 32'(mem_data), 0);
    chk("reset_sub_addr", 32'(sub_addr), 0);
    chk("reset_err_code", 32'(err_code), 0);

    // Basic three-word message to SA2
    cmd(16'h2843); data(16'h1111); data(16'h2222); data(16'h3333);
    idle(3);
    chk("basic_sub_addr", 32'(sub_addr), 32'd2);

    // Full 32-word message, then a stray data word that must not write
    cmd(16'h2840);
    for (int i = 0; i < 32; i++) begin
      data(16'hA000 + 16'(i));
      if (i % 7 == 3) idle(1);
    end
    data(16'hBEEF);
    idle(2);

    // Parity abort after one word
    cmd(16'h2843); data(16'h4444); step(1, 16'h5555, 0, 1); idle(2); data(16'h6666); idle(2);

    // Interrupting command restarts with SA1, two words
    cmd(16'h2843); data(16'h7777); cmd(16'h2822); data(16'h8888); data(16'h9999); idle(2);

    // Gap timeout, then broadcast accepted and foreign commands ignored
    cmd(16'h2843); idle(GAP + 3);
    cmd(16'hF843); data(16'h0101); data(16'h0202); data(16'h0303); idle(2);
    cmd(16'h3043); data(16'h0404); idle(1);
    cmd(16'h2C43); data(16'h0505); idle(1);
    cmd(16'h2803); data(16'h0606); idle(1);
    cmd(16'h2BE3); data(16'h0707); idle(1);

    // Reset mid-message discards the rest without a pulse
    cmd(16'h2843); data(16'h0808); do_reset(); idle(5); data(16'h0909); idle(2);

    // Randomized traffic
    for (int m = 0; m < 200; m++) begin
      r  = int'($urandom_range(0, 9));
      rt = (r == 0) ? 5'($urandom) : (r < 3 ? 5'd31 : MY_RT);
      tr = ($urandom_range(0, 15) == 0);
      sa = 5'($urandom);
      wc = 5'($urandom);
      cw = {rt, tr, sa, wc};
      step(1, cw, 1, ($urandom_range(0, 19) == 0));
      n        = (wc == 5'd0) ? 32 : int'(wc);
      long_gap = ($urandom_range(0, 39) == 0);
      gap_at   = int'($urandom_range(0, 31));
      for (int i = 0; i < n; i++) begin
        idle(int'($urandom_range(0, 2)));
        if (long_gap && i == gap_at) idle(GAP);
        r = int'($urandom_range(0, 99));
        if (r == 0)      step(1, 16'($urandom), 0, 1);
        else if (r == 1) step(1, 16'($urandom), 1, 0);
        else if (r == 2) do_reset();
        else             data(16'($urandom));
      end
      idle(int'($urandom_range(0, 3)));
    end

    idle(10);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
